// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM state encoding and frame timing constants.
package uart_pkg;

   localparam int CLK_PER_BIT  = 2604;
   localparam int FRAME_BITS   = 10;
   localparam int FRAME_CYCLES = CLK_PER_BIT * FRAME_BITS;

   // Smallest power of two that covers one whole frame, so the watchdog never trips on a healthy transfer
   localparam int TIMEOUT_DEFAULT = 2 ** $clog2(FRAME_CYCLES);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle of the UART TX arbiter.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int BUS_WIDTH = 8
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           i_req;
   logic [NUM_REQ*BUS_WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]           i_lock;
   logic                         i_tx_hs;
   logic [NUM_REQ-1:0]           o_grant;
   logic [BUS_WIDTH-1:0]         o_tx_bus;
   logic                         o_tx_start;
   logic                         o_busy;
   logic [IDX_W-1:0]             o_owner;
   logic                         o_timeout;

   // master = requesters plus transmitter, slave = the arbiter itself
   modport master (
      output i_req, i_req_data, i_lock, i_tx_hs,
      input  o_grant, o_tx_bus, o_tx_start, o_busy, o_owner, o_timeout
   );

   modport slave (
      input  i_req, i_req_data, i_lock, i_tx_hs,
      output o_grant, o_tx_bus, o_tx_start, o_busy, o_owner, o_timeout
   );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping past NUM_REQ-1.
module uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   index,
   output logic               valid
);

   function automatic int wrap_slot(input int base, input int offset);
      int slot;
      slot = base + offset;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      return slot;
   endfunction

   // Scan from the farthest offset down so the closest hit to ptr is the one left standing
   always_comb begin
      winner = '0;
      index  = '0;
      valid  = 1'b0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         if (req[wrap_slot(int'(ptr), off)]) begin
            winner = '0;
            winner[wrap_slot(int'(ptr), off)] = 1'b1;
            index  = IDX_W'(wrap_slot(int'(ptr), off));
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_LOCK_EN to let a locked owner keep the pointer across a multi-byte packet.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int BUS_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input logic              i_clk,
   input logic              i_rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_e state, state_next;

   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [BUS_WIDTH-1:0] tx_bus_q, tx_bus_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 timeout_q, timeout_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [WD_W-1:0]      wd_q, wd_d;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IDX_W-1:0]     pick_index;
   logic                 pick_valid;
   logic [IDX_W-1:0]     ptr_after_owner;
   logic                 hold_owner;
   logic                 wd_expired;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (bus.i_req),
      .ptr    (ptr_q),
      .winner (pick_onehot),
      .index  (pick_index),
      .valid  (pick_valid)
   );

`ifdef UART_ARB_LOCK_EN
   assign hold_owner = bus.i_lock[owner_q] & bus.i_req[owner_q];
`else
   logic unused_lock;
   assign unused_lock = ^bus.i_lock;
   assign hold_owner  = 1'b0;
`endif

   assign wd_expired      = (wd_q == WD_LIMIT);
   assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         grant_q   <= '0;
         tx_bus_q  <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         owner_q   <= '0;
         ptr_q     <= '0;
         wd_q      <= '0;
      end else begin
         state     <= state_next;
         grant_q   <= grant_d;
         tx_bus_q  <= tx_bus_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         wd_q      <= wd_d;
      end
   end

   // A done pulse outranks the watchdog when both land in the same cycle
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:      if (pick_valid) state_next = LAUNCH;
         LAUNCH:    state_next = WAIT_DONE;
         WAIT_DONE: if (bus.i_tx_hs || wd_expired) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      grant_d   = '0;
      start_d   = 1'b0;
      timeout_d = 1'b0;
      tx_bus_d  = tx_bus_q;
      busy_d    = busy_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      wd_d      = wd_q;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_d  = pick_onehot;
               tx_bus_d = bus.i_req_data[int'(pick_index) * BUS_WIDTH +: BUS_WIDTH];
               owner_d  = pick_index;
               busy_d   = 1'b1;
            end
         end
         LAUNCH: begin
            start_d = 1'b1;
            wd_d    = '0;
         end
         WAIT_DONE: begin
            wd_d = wd_q + 1'b1;
            if (bus.i_tx_hs) begin
               ptr_d  = hold_owner ? owner_q : ptr_after_owner;
               busy_d = 1'b0;
            end else if (wd_expired) begin
               timeout_d = 1'b1;
               ptr_d     = ptr_after_owner;
               busy_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.o_grant    = grant_q;
   assign bus.o_tx_bus   = tx_bus_q;
   assign bus.o_tx_start = start_q;
   assign bus.o_busy     = busy_q;
   assign bus.o_owner    = owner_q;
   assign bus.o_timeout  = timeout_q;

endmodule
